maxpool_tile_sched: RTL and testbench
=====================================

Name: maxpool_tile_sched

Overview:
- Sequencer that feeds the 2x2 max-pooling core (maxpooling_2x2) from a serial pixel stream and serializes its results.
- Collects one 4x4 tile of Q4.6 samples in raster order and reorders them into the four 2x2 windows the core expects.
- Registers the core's 2x2 result, then emits it as four output beats.
- Sits between the convolution/activation stream and the next layer's input buffer.

Parameters:
- DATA_W, 10 (BITS_Q4_6): width of one Q4.6 sample.
- CNT_W, 8: width of the completed-tile counter.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous active-high reset
- in_data  input  DATA_W  input sample, raster order within the tile
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  DATA_W  pooled sample
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_last  output  1  high on the 4th (final) output beat of a tile
- busy  output  1  high whenever state is not FILL with a zero fill count
- tiles_done  output  CNT_W  count of fully drained tiles; wraps modulo 2^CNT_W

Behaviour:
- Reset: applies synchronously on the clk edge where rst=1 and has priority over every other event.
  - State goes to FILL with fill count 0.
  - Output values after reset: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, tiles_done=0.
  - Any partial tile, or any undrained result, is discarded.
- FILL:
  - in_ready=1 and out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - Fill count k (0..15) maps the sample to row r=k/4 and column c=k%4.
  - It is written to window w = (r/2) + 2*(c/2), lane p = 2*(r%2) + (c%2).
  - Window w drives core input vector w; lanes p0..p3 map to p=0..3.
  - Acceptance of the 16th sample (k=15) moves the state to POOL and wraps k to 0.
- POOL (exactly 1 cycle):
  - in_ready=0.
  - The core's combinational outputs are registered into a 4-entry result buffer in row-major output order:
    - R0 = out(0,0) from window 0
    - R1 = out(0,1) from window 2
    - R2 = out(1,0) from window 1
    - R3 = out(1,1) from window 3
  - The tile register remains stable during this cycle.
- DRAIN:
  - in_ready=0; out_valid=1; out_data=R[j], where j is the drain index 0..3.
  - out_last = (j==3).
  - When out_valid && out_ready: j increments.
  - On j==3, state returns to FILL, j clears, and tiles_done increments.
  - out_data and out_last hold stable while out_valid=1 and out_ready=0.
- Latency: 16th input accepted at edge T → POOL during cycle T..T+1 → first out_valid=1 from edge T+1; no bubble between beats if out_ready stays high.
- Throughput: 16 input cycles + 1 POOL cycle + 4 drain cycles = 21 cycles per tile minimum; no overlap of fill and drain.
- Comparison semantics are those of the core: unsigned compare on raw DATA_W-bit codes. With the optional feature disabled, negative Q4.6 values therefore compare as large.
- in_valid while in_ready=0: data is ignored, not stored; upstream must hold it.
- out_ready while out_valid=0: ignored.
- tiles_done wraps from 2^CNT_W−1 to 0 with no flag.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: each sample is clamped at capture; if in_data[DATA_W-1]=1 (negative), 0 is stored instead. This makes ReLU+max-pool correct under the core's unsigned compare.
- Undefined: samples are stored unmodified; pooling is an unsigned raw-code max.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 → in_ready=1, out_valid=0, busy=0, tiles_done=0.
- Raster tile 0x000..0x00F, in_valid=1 continuous, out_ready=1 → outputs 0x005, 0x007, 0x00D, 0x00F; out_last only on 0x00F; first out_valid 1 cycle after the 16th acceptance edge; tiles_done=1.
- Backpressure: tile of all 0x040 except sample k=10 = 0x1FF; out_ready low 3 cycles at beat 2 → outputs 0x040, 0x040, 0x040, 0x1FF. out_data stays stable while stalled; in_ready stays 0 throughout DRAIN.
- Sign handling: tile with sample 0 = 0x3C0 (−1.0), others 0x010.
  - Without MAXPOOL_RELU_EN: first output 0x3C0.
  - With MAXPOOL_RELU_EN: first output 0x010.
- Reset mid-operation: accept 9 samples, assert rst 1 cycle, then send a fresh 16-sample tile of 0x001..0x010 → outputs 0x006, 0x008, 0x00E, 0x010. There is no residue from the aborted tile; tiles_done=1.
- Counter wrap with CNT_W=2: drain 5 tiles → tiles_done sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/maxpool_tile_sched.sv
// Tile sequencer for 2x2 max pooling: gathers a raster-ordered 4x4 tile, pools it, drains four beats.
// Optional MAXPOOL_RELU_EN clamps negative samples to zero as they are captured.

module maxpool_win_max #(
    parameter int DATA_W = 10
) (
    input  logic [3:0][DATA_W-1:0] lanes,
    output logic [DATA_W-1:0]      max
);
    logic [DATA_W-1:0] m01, m23;

    // Unsigned compare on raw codes, same as the pooling core.
    assign m01 = (lanes[1] > lanes[0]) ? lanes[1] : lanes[0];
    assign m23 = (lanes[3] > lanes[2]) ? lanes[3] : lanes[2];
    assign max = (m23 > m01) ? m23 : m01;
endmodule

module maxpool_tile_sched #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  tiles_done
);
    typedef enum logic [1:0] {FILL, POOL, DRAIN} state_t;

    state_t state, state_nxt;
    logic [3:0]                   k;
    logic [1:0]                   j;
    logic [3:0][3:0][DATA_W-1:0]  tile;     // [window][lane]
    logic [3:0][DATA_W-1:0]       win_max;
    logic [3:0][DATA_W-1:0]       res;
    logic [CNT_W-1:0]             cnt;
    logic [DATA_W-1:0]            cap;
    logic [1:0]                   w_idx, p_idx;

`ifdef MAXPOOL_RELU_EN
    assign cap = in_data[DATA_W-1] ? '0 : in_data;
`else
    assign cap = in_data;
`endif

    // k = {r[1:0], c[1:0]}: window = {c[1], r[1]}, lane = {r[0], c[0]}.
    assign w_idx = {k[1], k[3]};
    assign p_idx = {k[2], k[0]};

    genvar gw;
    generate
        for (gw = 0; gw < 4; gw++) begin : g_win
            maxpool_win_max #(.DATA_W(DATA_W)) u_max (
                .lanes (tile[gw]),
                .max   (win_max[gw])
            );
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && k == 4'd15) state_nxt = POOL;
            end
            POOL: state_nxt = DRAIN;
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = res[j];
                out_last  = (j == 2'd3);
                if (out_ready && j == 2'd3) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            k     <= '0;
            j     <= '0;
            cnt   <= '0;
            tile  <= '0;
            res   <= '0;
        end else begin
            state <= state_nxt;
            if (state == FILL && in_valid) begin
                tile[w_idx][p_idx] <= cap;
                k                  <= k + 4'd1;
            end
            // Result buffer is held in row-major output order.
            if (state == POOL) begin
                res[0] <= win_max[0];
                res[1] <= win_max[2];
                res[2] <= win_max[1];
                res[3] <= win_max[3];
            end
            if (state == DRAIN && out_ready) begin
                j <= j + 2'd1;
                if (j == 2'd3) cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign busy       = !(state == FILL && k == 4'd0);
    assign tiles_done = cnt;
endmodule

// File: tb/tb_maxpool_tile_sched.sv
// Scoreboard bench for maxpool_tile_sched: directed tiles, backpressure, sign, mid-tile reset, counter wrap.
module tb_maxpool_tile_sched;
    localparam int DW = 10;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic [CW-1:0] tiles_done;

    maxpool_tile_sched #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .tiles_done (tiles_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [DW-1:0] tile_buf [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Monitor: samples just after the falling edge, when stimulus for the next rising edge is settled.
    initial begin : monitor
        logic          held_v;
        logic [DW-1:0] held;
        exp_t          e;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("stall_valid", out_valid, 1);
                    if (out_valid) chk("stall_data", out_data, held);
                end
                held_v = 1'b0;
                if (out_valid) begin
                    chk("in_ready_drain", in_ready, 0);
                    if (out_ready) begin
                        if (q.size() == 0) begin
                            fail_now("unexpected_beat");
                        end else begin
                            e = q.pop_front();
                            chk("out_data", out_data, e.d);
                            chk("out_last", out_last, e.l);
                        end
                    end else begin
                        held_v = 1'b1;
                        held   = out_data;
                    end
                end
            end
        end
    end

    task automatic expect4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        q.push_back('{d: a, l: 1'b0});
        q.push_back('{d: b, l: 1'b0});
        q.push_back('{d: c, l: 1'b0});
        q.push_back('{d: d, l: 1'b1});
    endtask

    task automatic push(input logic [DW-1:0] d);
        int b;
        b = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) fail_now("push_timeout");
        @(posedge clk);
    endtask

    task automatic send_tile();
        for (int i = 0; i < 16; i++) push(tile_buf[i]);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int b;
        b = 0;
        while ((q.size() != 0 || busy) && b < 200) begin
            @(negedge clk);
            b++;
        end
        if (b >= 200) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset then idle
        do_reset(2);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tiles_done", tiles_done, 0);

        // Raster tile 0..15, with first-beat latency check
        for (int i = 0; i < 16; i++) tile_buf[i] = DW'(i);
        expect4(10'h005, 10'h007, 10'h00D, 10'h00F);
        for (int i = 0; i < 16; i++) push(tile_buf[i]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pool_out_valid", out_valid, 0);
        chk("pool_in_ready", in_ready, 0);
        chk("pool_busy", busy, 1);
        @(negedge clk);
        chk("first_valid_latency", out_valid, 1);
        wait_drain();
        chk("tiles_done_1", tiles_done, 1);

        // Backpressure on beat 2 for 3 cycles
        for (int i = 0; i < 16; i++) tile_buf[i] = 10'h040;
        tile_buf[10] = 10'h1FF;
        expect4(10'h040, 10'h040, 10'h040, 10'h1FF);
        send_tile();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_valid_at_stall", out_valid, 1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        wait_drain();
        chk("tiles_done_2", tiles_done, 2);

        // Sign handling
        for (int i = 0; i < 16; i++) tile_buf[i] = 10'h010;
        tile_buf[0] = 10'h3C0;
`ifdef MAXPOOL_RELU_EN
        expect4(10'h010, 10'h010, 10'h010, 10'h010);
`else
        expect4(10'h3C0, 10'h010, 10'h010, 10'h010);
`endif
        send_tile();
        wait_drain();
        chk("tiles_done_3", tiles_done, 3);

        // Reset in the middle of a tile; aborted samples are large to expose residue
        for (int i = 0; i < 9; i++) push(10'h3FF);
        do_reset(1);
        chk("midrst_busy", busy, 0);
        chk("midrst_tiles_done", tiles_done, 0);
        for (int i = 0; i < 16; i++) tile_buf[i] = DW'(i + 1);
        expect4(10'h006, 10'h008, 10'h00E, 10'h010);
        send_tile();
        wait_drain();
        chk("midrst_tiles_done_1", tiles_done, 1);

        // Counter wrap with a 2-bit counter
        do_reset(1);
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 16; i++) tile_buf[i] = DW'(t + 2);
            expect4(DW'(t + 2), DW'(t + 2), DW'(t + 2), DW'(t + 2));
            send_tile();
            wait_drain();
            chk($sformatf("wrap_tiles_done_%0d", t), tiles_done, (t + 1) % 4);
        end

        chk("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
